// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Holds tag/valid/dirty state, sequences the external 1024 x 128-bit line
// array and moves whole lines to and from memory over a valid/ready handshake.
module cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 10,
  parameter int LINE_W  = 128,
  parameter int WORD_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_valid,
  input  logic              i_cpu_rw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [WORD_W-1:0] i_cpu_wdata,
  output logic [WORD_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic [INDEX_W-1:0] o_arr_index,
  output logic              o_arr_we,
  output logic [LINE_W-1:0] o_arr_wdata,
  input  logic [LINE_W-1:0] i_arr_rdata,
  output logic              o_mem_valid,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic [LINE_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
);

  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORDS    = LINE_W / WORD_W;
  localparam int SEL_W    = $clog2(WORDS);
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t              r_state;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_W-1:0]    r_tag_mem [LINES];
  logic                r_mem_valid;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [SEL_W-1:0]    w_word;
  logic [TAG_W-1:0]    w_old_tag;
  logic                w_hit;
  logic                w_compare_hit;
  logic                w_fill;
  logic [WORD_W-1:0]   w_rd_word;
  logic [LINE_W-1:0]   w_merged;
  logic                w_unused;

  assign w_tag         = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx         = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_word        = r_addr[SEL_W+1:2];
  assign w_old_tag     = r_tag_mem[w_idx];
  assign w_hit         = r_valid[w_idx] && (w_old_tag == w_tag);
  assign w_compare_hit = (r_state == S_COMPARE) && w_hit;
  assign w_fill        = (r_state == S_ALLOCATE) && r_mem_valid && i_mem_ready;
  assign w_unused      = ^r_addr[1:0];

  // Pick the addressed word out of the current line and build the line with that word replaced
  always_comb begin
    w_rd_word = '0;
    w_merged  = i_arr_rdata;
    for (int i = 0; i < WORDS; i++) begin
      if (w_word == SEL_W'(i)) begin
        w_rd_word                    = i_arr_rdata[i*WORD_W +: WORD_W];
        w_merged[i*WORD_W +: WORD_W] = r_wdata;
      end
    end
  end

  assign o_arr_index = (r_state == S_IDLE) ? i_cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W] : w_idx;
  assign o_arr_we    = (w_compare_hit && r_rw) || w_fill;
  assign o_arr_wdata = w_fill ? i_mem_rdata : w_merged;
  assign o_cpu_ready = w_compare_hit;
  assign o_cpu_rdata = w_compare_hit ? w_rd_word : '0;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_rw    = r_mem_rw;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = (r_state == S_WRITEBACK) ? i_arr_rdata : '0;

  // Tag storage is written only when a fill completes; it needs no reset because valid gates it
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tag_mem[w_idx] <= w_tag;
    end
  end

  // Main controller: request latch, hit/miss decision, writeback and allocate sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cpu_valid) begin
            r_rw    <= i_cpu_rw;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (r_rw) begin
              r_dirty[w_idx] <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
            r_mem_valid <= 1'b1;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= {w_old_tag, w_idx, {OFFSET_W{1'b0}}};
            r_state     <= S_WRITEBACK;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
            r_state     <= S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_state     <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
          end else if (i_mem_ready) begin
            r_mem_valid    <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_COMPARE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: models the line array and main memory,
// and predicts every CPU result and memory transaction from a flat word view
// of memory plus a transaction-level direct-mapped cache model.
module tb_cache_ctrl;

  logic         clk;
  logic         rstN;
  logic         cpuValid;
  logic         cpuRw;
  logic [31:0]  cpuAddr;
  logic [31:0]  cpuWdata;
  logic [31:0]  cpuRdata;
  logic         cpuReady;
  logic [9:0]   arrIndex;
  logic         arrWe;
  logic [127:0] arrWdata;
  logic [127:0] arrRdata;
  logic         memValid;
  logic         memRw;
  logic [31:0]  memAddr;
  logic [127:0] memWdata;
  logic [127:0] memRdata;
  logic         memReady;

  int nCompared;
  int nMismatched;

  logic [127:0] arrMem [1024];
  logic [127:0] dram [logic [31:0]];
  logic [31:0]  refWord [logic [31:0]];
  logic [17:0]  mTag [1024];
  bit           mValid [1024];
  bit           mDirty [1024];

  cache_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_cpu_valid (cpuValid),
    .i_cpu_rw    (cpuRw),
    .i_cpu_addr  (cpuAddr),
    .i_cpu_wdata (cpuWdata),
    .o_cpu_rdata (cpuRdata),
    .o_cpu_ready (cpuReady),
    .o_arr_index (arrIndex),
    .o_arr_we    (arrWe),
    .o_arr_wdata (arrWdata),
    .i_arr_rdata (arrRdata),
    .o_mem_valid (memValid),
    .o_mem_rw    (memRw),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_rdata (memRdata),
    .i_mem_ready (memReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external line array: clocked write, combinational read
  always_ff @(posedge clk) begin
    if (arrWe) arrMem[arrIndex] <= arrWdata;
  end
  assign arrRdata = arrMem[arrIndex];

  // Main memory contents: explicit entries override a per-address pattern
  function automatic logic [127:0] dramLine(input logic [31:0] la);
    logic [127:0] l;
    if (dram.exists(la)) return dram[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = ((la + 32'(i*4)) * 32'h9E3779B9) ^ 32'h5A5A0000;
    return l;
  endfunction

  // What the CPU should see at a word address if the cache were invisible
  function automatic logic [31:0] expWord(input logic [31:0] a);
    logic [31:0]  wa;
    logic [127:0] l;
    wa = {a[31:2], 2'b00};
    if (refWord.exists(wa)) return refWord[wa];
    l = dramLine({a[31:4], 4'h0});
    return l[int'(a[3:2])*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    refWord.delete();
  endtask

  // Predict one CPU access, then update the cache and word views
  task automatic model_access(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                              output bit expHit, output bit expWb, output logic [31:0] expWbAddr,
                              output logic [127:0] expWbData, output logic [31:0] expFillAddr,
                              output logic [31:0] expRdata);
    logic [9:0]  idx;
    logic [17:0] tag;
    idx         = addr[13:4];
    tag         = addr[31:14];
    expRdata    = expWord(addr);
    expHit      = mValid[idx] && (mTag[idx] == tag);
    expWb       = !expHit && mValid[idx] && mDirty[idx];
    expWbAddr   = {mTag[idx], idx, 4'h0};
    for (int i = 0; i < 4; i++) expWbData[i*32 +: 32] = expWord(expWbAddr + 32'(i*4));
    expFillAddr = {tag, idx, 4'h0};
    if (!expHit) begin
      mTag[idx]   = tag;
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
    end
    if (rw) begin
      mDirty[idx] = 1'b1;
      refWord[{addr[31:2], 2'b00}] = wdata;
    end
  endtask

  // Drive one CPU request, act as memory with the given latency, and report what was observed
  task automatic do_access(input bit rw, input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                           output int cycles, output logic [31:0] rdata, output int nWb, output int nFill,
                           output logic [31:0] wbAddr, output logic [127:0] wbData, output logic [31:0] fillAddr,
                           output bit sawWe, output bit timedOut, output bit protoOk);
    bit           active;
    bit           done;
    int           waitCnt;
    logic         firstRw;
    logic [31:0]  firstAddr;
    logic [127:0] firstWdata;
    cycles = 0; rdata = '0; nWb = 0; nFill = 0; wbAddr = '0; wbData = '0; fillAddr = '0;
    sawWe = 0; timedOut = 0; protoOk = 1; active = 0; done = 0; waitCnt = 0;
    firstRw = 0; firstAddr = '0; firstWdata = '0;
    @(negedge clk);
    cpuValid = 1'b1; cpuRw = rw; cpuAddr = addr; cpuWdata = wdata;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (memReady) begin
        memReady = 1'b0;
        active   = 0;
        if (memValid) protoOk = 0;
      end else if (memValid) begin
        if (!active) begin
          active = 1; waitCnt = 0;
          firstRw = memRw; firstAddr = memAddr; firstWdata = memWdata;
          if (memRw) begin nWb++; wbAddr = memAddr; wbData = memWdata; end
          else begin nFill++; fillAddr = memAddr; end
        end else if (memRw !== firstRw || memAddr !== firstAddr || (firstRw && memWdata !== firstWdata)) begin
          protoOk = 0;
        end
        if (cpuReady) protoOk = 0;
        if (waitCnt == lat) begin
          memReady = 1'b1;
          if (memRw) dram[memAddr] = memWdata;
          else memRdata = dramLine(memAddr);
        end
        waitCnt++;
      end
      if (cpuReady) begin
        done = 1; rdata = cpuRdata; sawWe = arrWe; cpuValid = 1'b0;
      end else if (cycles >= 200) begin
        done = 1; timedOut = 1; cpuValid = 1'b0; memReady = 1'b0;
      end
    end
  endtask

  // Outputs during and just after an asynchronous reset
  task automatic test_reset();
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #1;
    model_reset();
    nCompared++; if (cpuReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cpu_ready: got %b, expected 0", cpuReady); end
    nCompared++; if (arrWe !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_arr_we: got %b, expected 0", arrWe); end
    nCompared++; if (memValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_valid: got %b, expected 0", memValid); end
    nCompared++; if (memRw !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_rw: got %b, expected 0", memRw); end
    nCompared++; if (cpuRdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_cpu_rdata: got %h, expected 0", cpuRdata); end
    nCompared++; if (memAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0", memAddr); end
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    nCompared++; if (memValid !== 1'b0 || cpuReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_idle: got mem_valid=%b cpu_ready=%b, expected 0/0", memValid, cpuReady); end
  endtask

  // Cold read miss, then the repeated read that must hit with one-cycle latency
  task automatic test_read_miss_hit();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb;
    dram[32'h10] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    model_access(0, 32'h14, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h14, 0, 3, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (to || nWb !== 0 || nFill !== 1) begin nMismatched++; $display("[TB] FAIL miss_txns: got wb=%0d fill=%0d timeout=%b, expected 0/1/0", nWb, nFill, to); end
    nCompared++; if (fillA !== 32'h10) begin nMismatched++; $display("[TB] FAIL miss_fill_addr: got %h, expected 00000010", fillA); end
    nCompared++; if (rd !== 32'hBBBBBBBB || rd !== eRd) begin nMismatched++; $display("[TB] FAIL miss_rdata: got %h, expected bbbbbbbb", rd); end
    model_access(0, 32'h14, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h14, 0, 3, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (cyc !== 1 || nFill !== 0 || nWb !== 0) begin nMismatched++; $display("[TB] FAIL hit_latency: got cycles=%0d fills=%0d wbs=%0d, expected 1/0/0", cyc, nFill, nWb); end
    nCompared++; if (rd !== eRd) begin nMismatched++; $display("[TB] FAIL hit_rdata: got %h, expected %h", rd, eRd); end
  endtask

  // Write hit replaces one word and a following read returns it
  task automatic test_write_hit();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb;
    model_access(1, 32'h18, 32'h12345678, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(1, 32'h18, 32'h12345678, 2, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (cyc !== 1 || we !== 1'b1 || nFill !== 0) begin nMismatched++; $display("[TB] FAIL write_hit: got cycles=%0d arr_we=%b fills=%0d, expected 1/1/0", cyc, we, nFill); end
    nCompared++; if (rd !== 32'hCCCCCCCC) begin nMismatched++; $display("[TB] FAIL write_hit_old_word: got %h, expected cccccccc", rd); end
    model_access(0, 32'h18, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h18, 0, 2, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (rd !== 32'h12345678 || we !== 1'b0) begin nMismatched++; $display("[TB] FAIL read_after_write: got %h we=%b, expected 12345678 we=0", rd, we); end
  endtask

  // Conflicting read evicts the dirty line through a writeback, then allocates
  task automatic test_dirty_evict();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb;
    model_access(0, 32'h4010, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h4010, 0, 1, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (to || nWb !== 1 || nFill !== 1 || !ok) begin nMismatched++; $display("[TB] FAIL evict_txns: got wb=%0d fill=%0d proto=%b timeout=%b, expected 1/1/1/0", nWb, nFill, ok, to); end
    nCompared++; if (wbA !== 32'h10) begin nMismatched++; $display("[TB] FAIL evict_wb_addr: got %h, expected 00000010", wbA); end
    nCompared++; if (wbD[95:64] !== 32'h12345678 || wbD !== eWbD) begin nMismatched++; $display("[TB] FAIL evict_wb_data: got %h, expected %h", wbD, eWbD); end
    nCompared++; if (fillA !== 32'h4010) begin nMismatched++; $display("[TB] FAIL evict_fill_addr: got %h, expected 00004010", fillA); end
    nCompared++; if (rd !== eRd) begin nMismatched++; $display("[TB] FAIL evict_rdata: got %h, expected %h", rd, eRd); end
  endtask

  // Memory holds off for 8 cycles during a writeback; the request must stay frozen
  task automatic test_wb_stall();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb;
    model_access(1, 32'h4014, 32'hCAFEF00D, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(1, 32'h4014, 32'hCAFEF00D, 0, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    model_access(0, 32'h14, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h14, 0, 8, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (!ok || to) begin nMismatched++; $display("[TB] FAIL stall_stable: got proto=%b timeout=%b, expected 1/0", ok, to); end
    nCompared++; if (nWb !== 1 || wbA !== 32'h4010 || wbD !== eWbD) begin nMismatched++; $display("[TB] FAIL stall_wb: got n=%0d addr=%h data=%h, expected 1 00004010 %h", nWb, wbA, wbD, eWbD); end
    nCompared++; if (cyc < 10 || rd !== eRd) begin nMismatched++; $display("[TB] FAIL stall_result: got cycles=%0d rdata=%h, expected >=10 %h", cyc, rd, eRd); end
  endtask

  // Reset while a fill is outstanding abandons it; the same read misses afterwards
  task automatic test_reset_mid_alloc();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb, seen;
    seen = 0;
    @(negedge clk);
    cpuValid = 1'b1; cpuRw = 1'b0; cpuAddr = 32'h8020; cpuWdata = '0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (memValid && !memRw) seen = 1;
    end
    nCompared++; if (!seen) begin nMismatched++; $display("[TB] FAIL rst_alloc_start: got no fill request, expected one within 20 cycles"); end
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    nCompared++; if (memValid !== 1'b0 || arrWe !== 1'b0 || cpuReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_outputs: got mem_valid=%b arr_we=%b cpu_ready=%b, expected 0/0/0", memValid, arrWe, cpuReady); end
    cpuValid = 1'b0;
    memReady = 1'b0;
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    model_access(0, 32'h8020, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h8020, 0, 2, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (nFill !== 1 || nWb !== 0 || fillA !== 32'h8020) begin nMismatched++; $display("[TB] FAIL rst_reread_miss: got fill=%0d wb=%0d addr=%h, expected 1/0/00008020", nFill, nWb, fillA); end
    nCompared++; if (rd !== eRd) begin nMismatched++; $display("[TB] FAIL rst_reread_data: got %h, expected %h", rd, eRd); end
  endtask

  // Lines 1023 and 0 are independent
  task automatic test_index_wrap();
    int cyc, nWb, nFill; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb;
    model_access(1, 32'h3FF4, 32'h11112222, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(1, 32'h3FF4, 32'h11112222, 1, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    model_access(1, 32'h0004, 32'h33334444, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(1, 32'h0004, 32'h33334444, 1, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    model_access(0, 32'h3FF4, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h3FF4, 0, 1, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (rd !== 32'h11112222 || nFill !== 0) begin nMismatched++; $display("[TB] FAIL wrap_1023: got %h fills=%0d, expected 11112222 0", rd, nFill); end
    model_access(0, 32'h0004, 0, eHit, eWb, eWbA, eWbD, eFillA, eRd);
    do_access(0, 32'h0004, 0, 1, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
    nCompared++; if (rd !== 32'h33334444 || nFill !== 0) begin nMismatched++; $display("[TB] FAIL wrap_0: got %h fills=%0d, expected 33334444 0", rd, nFill); end
  endtask

  // Random reads and writes over a few conflicting tags and indices, back to back
  task automatic test_random();
    int cyc, nWb, nFill, lat; logic [31:0] rd, wbA, fillA, eWbA, eFillA, eRd, a, wd; logic [127:0] wbD, eWbD;
    bit we, to, ok, eHit, eWb, rw;
    int idxs[4];
    idxs = '{0, 1, 2, 1023};
    for (int it = 0; it < 80; it++) begin
      a   = {16'h0, 2'($urandom_range(0, 3)), 10'(idxs[$urandom_range(0, 3)]), 2'($urandom_range(0, 3)), 2'b00};
      rw  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      lat = $urandom_range(0, 4);
      model_access(rw, a, wd, eHit, eWb, eWbA, eWbD, eFillA, eRd);
      do_access(rw, a, wd, lat, cyc, rd, nWb, nFill, wbA, wbD, fillA, we, to, ok);
      nCompared++; if (to || !ok) begin nMismatched++; $display("[TB] FAIL rnd_proto[%0d]: got timeout=%b proto=%b, expected 0/1", it, to, ok); end
      nCompared++; if (rd !== eRd) begin nMismatched++; $display("[TB] FAIL rnd_rdata[%0d] addr %h: got %h, expected %h", it, a, rd, eRd); end
      nCompared++; if (nWb !== (eWb ? 1 : 0) || nFill !== (eHit ? 0 : 1)) begin nMismatched++; $display("[TB] FAIL rnd_txns[%0d]: got wb=%0d fill=%0d, expected %0d/%0d", it, nWb, nFill, eWb, !eHit); end
      nCompared++; if (we !== rw) begin nMismatched++; $display("[TB] FAIL rnd_arr_we[%0d]: got %b, expected %b", it, we, rw); end
      if (eWb) begin
        nCompared++; if (wbA !== eWbA || wbD !== eWbD) begin nMismatched++; $display("[TB] FAIL rnd_wb[%0d]: got %h %h, expected %h %h", it, wbA, wbD, eWbA, eWbD); end
      end
      if (!eHit) begin
        nCompared++; if (fillA !== eFillA) begin nMismatched++; $display("[TB] FAIL rnd_fill_addr[%0d]: got %h, expected %h", it, fillA, eFillA); end
      end else begin
        nCompared++; if (cyc !== 1) begin nMismatched++; $display("[TB] FAIL rnd_hit_latency[%0d]: got %0d, expected 1", it, cyc); end
      end
    end
  endtask

  // Absolute bound on the run in case anything stalls outside the per-access budgets
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared = 0; nMismatched = 0;
    cpuValid = 0; cpuRw = 0; cpuAddr = '0; cpuWdata = '0;
    memRdata = '0; memReady = 0;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_dirty_evict();
    test_wb_stall();
    test_reset_mid_alloc();
    test_index_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
